// File: rtl/timer_controller.sv
// Multi-channel timer: a shared prescaler feeds base ticks to per-channel period counters.
// Optional sticky overrun flags are built when TIMER_CTRL_OVERRUN_EN is defined.
module timer_controller #(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] ack,
  output logic                tick,
  output logic [CHANNELS-1:0] active,
  // "event" is a reserved word, hence the plural.
  output logic [CHANNELS-1:0] events,
  output logic [CHANNELS-1:0] overrun
);

  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {StIdle, StRun} ch_state_e;

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick_q, tick_d;

  ch_state_e           state_q  [CHANNELS];
  ch_state_e           state_d  [CHANNELS];
  logic [PERIOD_W-1:0] count_q  [CHANNELS];
  logic [PERIOD_W-1:0] count_d  [CHANNELS];
  logic [PERIOD_W-1:0] period_q [CHANNELS];
  logic [PERIOD_W-1:0] period_d [CHANNELS];
  logic [CHANNELS-1:0] oneshot_q, oneshot_d;
  logic [CHANNELS-1:0] event_q, event_d;
  logic [CHANNELS-1:0] cfg_hit, expire;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (presc_q == PrescW'(PRESCALE - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end
  end

  // Out-of-range addresses never match any channel index.
  always_comb begin
    cfg_hit = '0;
    expire  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_hit[i] = cfg_we && (cfg_addr == 3'(i));
      expire[i]  = (state_q[i] == StRun) && tick_q &&
                   (count_q[i] == period_q[i] - PERIOD_W'(1));
    end
  end

  always_comb begin
    oneshot_d = oneshot_q;
    event_d   = event_q;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      if (cfg_hit[i]) begin
        // A config write beats both expiry and ack on the same edge.
        state_d[i]   = (cfg_period != '0) ? StRun : StIdle;
        count_d[i]   = '0;
        period_d[i]  = cfg_period;
        oneshot_d[i] = cfg_oneshot;
        event_d[i]   = 1'b0;
      end else begin
        if (expire[i]) begin
          count_d[i] = '0;
          event_d[i] = 1'b1;
          if (oneshot_q[i]) state_d[i] = StIdle;
        end else begin
          if ((state_q[i] == StRun) && tick_q) count_d[i] = count_q[i] + PERIOD_W'(1);
          if (ack[i]) event_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      oneshot_q <= '0;
      event_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= StIdle;
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      oneshot_q <= oneshot_d;
      event_q   <= event_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < CHANNELS; i++) active[i] = (state_q[i] == StRun);
  end

  assign tick   = tick_q;
  assign events = event_q;

`ifdef TIMER_CTRL_OVERRUN_EN
  logic [CHANNELS-1:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_hit[i]) begin
        overrun_d[i] = 1'b0;
      end else if (expire[i] && event_q[i] && !ack[i]) begin
        overrun_d[i] = 1'b1;
      end else if (ack[i]) begin
        overrun_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= '0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller (PRESCALE=4, CHANNELS=4, PERIOD_W=16).
module tb_timer_controller;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned PERIOD_W = 16;
`ifdef TIMER_CTRL_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_oneshot;
  logic [CHANNELS-1:0] ack;
  logic                tick;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] events;
  logic [CHANNELS-1:0] overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  timer_controller #(
    .PRESCALE (PRESCALE),
    .CHANNELS (CHANNELS),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .ack         (ack),
    .tick        (tick),
    .active      (active),
    .events      (events),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_period  = '0;
    cfg_oneshot = 1'b0;
    ack         = '0;
    step();
    step();
    reset = 1'b0;
    e     = 0;
  endtask

  task automatic cfg(input int ch, input int per, input bit os);
    cfg_we      = 1'b1;
    cfg_addr    = 3'(ch);
    cfg_period  = PERIOD_W'(per);
    cfg_oneshot = os;
  endtask

  initial begin
    // Test 1: prescaler cadence, nothing else moves
    do_reset();
    check("rst_out", 32'({tick, active, events, overrun}), 0);
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t1_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
      check("t1_quiet", 32'({active, events, overrun}), 0);
    end

    // Tests 2/3: periodic ch0 (period 3) and oneshot ch1 (period 2)
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 1)      cfg(0, 3, 1'b0);
      else if (k == 2) cfg(1, 2, 1'b1);
      else             cfg_we = 1'b0;
      step();
      check("t2_active", 32'(active), 1 | ((k >= 2 && k < 9) ? 2 : 0));
      check("t2_events", 32'(events), ((k >= 9) ? 2 : 0) | ((k >= 13) ? 1 : 0));
    end
    ack = 4'b0001;
    step();
    ack = '0;
    check("t2_ack", 32'(events), 2);
    while (e < 24) step();
    check("t2_pre_refire", 32'(events), 2);
    step();
    check("t2_refire", 32'(events), 3);
    check("t3_no_rearm", 32'(active), 1);
    cfg(1, 2, 1'b1);
    step();
    cfg_we = 1'b0;
    check("t3_rearm_act", 32'(active), 3);
    check("t3_rearm_evt", 32'(events), 1);
    while (e < 32) step();
    check("t3_pre_fire", 32'(events[1]), 0);
    step();
    check("t3_fire", 32'(events[1]), 1);
    check("t3_oneshot_drop", 32'(active), 1);

    // Test 4: boundary collisions on ch2, period 1
    do_reset();
    enable = 1'b1;
    cfg(2, 1, 1'b0);
    step();
    cfg_we = 1'b0;
    check("t4_arm", 32'(active), 4);
    while (e < 4) step();
    ack = 4'b0100;
    step();
    ack = '0;
    check("t4_ack_col_evt", 32'(events), 4);
    check("t4_ack_col_ovr", 32'(overrun), 0);
    while (e < 8) step();
    cfg(2, 1, 1'b0);
    step();
    cfg_we = 1'b0;
    check("t4_cfg_col_evt", 32'(events), 0);
    check("t4_cfg_col_act", 32'(active), 4);
    while (e < 12) step();
    check("t4_restart_pre", 32'(events), 0);
    step();
    check("t4_restart_fire", 32'(events), 4);
    check("t4_restart_ovr", 32'(overrun), 0);

    // Test 5: overrun on ch3, period 1, no ack
    do_reset();
    enable = 1'b1;
    cfg(3, 1, 1'b0);
    step();
    cfg_we = 1'b0;
    while (e < 5) step();
    check("t5_evt", 32'(events), 8);
    check("t5_ovr_first", 32'(overrun), 0);
    while (e < 9) step();
    check("t5_ovr", 32'(overrun), OvrEn ? 8 : 0);
    check("t5_evt_hold", 32'(events), 8);
    ack = 4'b1000;
    step();
    ack = '0;
    check("t5_ack_evt", 32'(events), 0);
    check("t5_ack_ovr", 32'(overrun), 0);

    // Test 6: enable freeze, then reset mid-run
    do_reset();
    enable = 1'b1;
    cfg(0, 3, 1'b0);
    step();
    cfg_we = 1'b0;
    while (e < 6) step();
    check("t6_pre", 32'(tick), 0);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t6_frz_tick", 32'(tick), 0);
      check("t6_frz_state", 32'({active, events}), 32'h10);
    end
    enable = 1'b1;
    step();
    check("t6_resume0", 32'(tick), 0);
    step();
    check("t6_resume1", 32'(tick), 1);
    while (e < 19) step();
    check("t6_late_pre", 32'(events), 0);
    step();
    check("t6_late_fire", 32'(events), 1);
    reset = 1'b1;
    cfg(0, 5, 1'b0);
    step();
    check("t6_reset", 32'({tick, active, events, overrun}), 0);
    reset = 1'b0;
    cfg(5, 1, 1'b0);
    step();
    cfg_we = 1'b0;
    check("t6_bad_addr", 32'(active), 0);
    while (e < 30) step();
    check("t6_idle", 32'({active, events, overrun}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
